// File: rtl/key_scan_snapshot_if.sv
// Purpose : read/hold port between the SPI slave and the key snapshot bank.
// Latency : rd_data_o is valid one core_clk cycle after a cycle with rd_en_i high.
// Backpr. : none; hold_i freezes bank writes while a byte is in flight.
// Ports   : hold_i, rd_en_i, rd_addr_i (SPI -> core), rd_data_o (core -> SPI).
interface key_scan_snapshot_if;
    logic       hold_i;
    logic       rd_en_i;
    logic [7:0] rd_addr_i;
    logic [7:0] rd_data_o;

    // SPI slave side drives requests.
    modport master (
        output hold_i,
        output rd_en_i,
        output rd_addr_i,
        input  rd_data_o
    );

    // Snapshot core side answers them.
    modport slave (
        input  hold_i,
        input  rd_en_i,
        input  rd_addr_i,
        output rd_data_o
    );
endinterface

// File: rtl/key_scan_snapshot.sv
// Purpose : sync + debounce NUM_KEYS switches, refresh a byte-wide snapshot bank.
// Latency : 2-flop sync, DEBOUNCE_DEPTH ticks to qualify, <= GROUPS cycles to bank, 1-cycle read.
// Backpr. : hold_i suppresses bank writes only; pointer, ticks and debounce keep running.
// Ports   : clk_g_int_buf, rstn_g_i (async low), keys_i raw levels, spi_bus (hold/read port),
//           keys_o debounced levels, key_tick_o sample-tick pulse, keys_valid_o first full sweep.
module key_scan_snapshot #(
    parameter int NUM_KEYS       = 61,
    parameter int TICK_PERIOD    = 400,
    parameter int DEBOUNCE_DEPTH = 4
) (
    input  logic                  clk_g_int_buf,
    input  logic                  rstn_g_i,
    input  logic [NUM_KEYS-1:0]   keys_i,
    key_scan_snapshot_if.slave    spi_bus,
    output logic [NUM_KEYS-1:0]   keys_o,
    output logic                  key_tick_o,
    output logic                  keys_valid_o
);
    localparam int GROUPS = (NUM_KEYS + 7) / 8;
    localparam int PTR_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    // Bank is sized to a power of two so the pointer/address can index it
    // without width games; entries at or above GROUPS are never written.
    localparam int DEPTH  = 1 << PTR_W;
    localparam int TICK_W = $clog2(TICK_PERIOD);
    localparam logic [8:0] GROUPS_W = 9'(GROUPS);

    logic [NUM_KEYS-1:0]       r_sync1;
    logic [NUM_KEYS-1:0]       r_sync2;
    logic [NUM_KEYS-1:0]       r_keys;
    logic [DEBOUNCE_DEPTH-1:0] r_hist [NUM_KEYS];
    logic [TICK_W-1:0]         r_tick_cnt;
    logic [PTR_W-1:0]          r_ptr;
    logic [7:0]                r_bank [DEPTH];
    logic [7:0]                r_rd_data;
    logic                      r_valid;

    logic                      w_tick;
    logic [8*DEPTH-1:0]        w_padded;
    logic [7:0]                w_wr_byte;
    logic                      w_wr_en;
    logic                      w_ptr_last;

    assign w_tick     = (r_tick_cnt == TICK_W'(TICK_PERIOD - 1));
    assign w_ptr_last = (r_ptr == PTR_W'(GROUPS - 1));
    assign w_wr_en    = ~spi_bus.hold_i;

    // Unused upper bits stay zero so padding in the last group reads 0.
    always_comb begin
        w_padded                 = '0;
        w_padded[NUM_KEYS-1:0]   = r_keys;
    end
    assign w_wr_byte = w_padded[{r_ptr, 3'b000} +: 8];

    assign keys_o            = r_keys;
    assign key_tick_o        = w_tick;
    assign keys_valid_o      = r_valid;
    assign spi_bus.rd_data_o = r_rd_data;

    // Synchroniser, tick generator and debounce.
    always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_keys     <= '0;
            r_tick_cnt <= '0;
            for (int n = 0; n < NUM_KEYS; n++) begin
                r_hist[n] <= '0;
            end
        end else begin
            r_sync1 <= keys_i;
            r_sync2 <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                for (int n = 0; n < NUM_KEYS; n++) begin
                    r_hist[n] <= {r_hist[n][DEBOUNCE_DEPTH-2:0], r_sync2[n]};
                    // The shifted history is all-equal exactly when the older
                    // DEBOUNCE_DEPTH-1 samples already match the new one.
                    if (r_hist[n][DEBOUNCE_DEPTH-2:0] == {(DEBOUNCE_DEPTH-1){r_sync2[n]}}) begin
                        r_keys[n] <= r_sync2[n];
                    end
                end
            end
        end
    end

    // Group pointer, bank refresh, read port and sweep-valid flag.
    always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            r_ptr     <= '0;
            r_rd_data <= '0;
            r_valid   <= 1'b0;
            for (int g = 0; g < DEPTH; g++) begin
                r_bank[g] <= '0;
            end
        end else begin
            r_ptr <= w_ptr_last ? '0 : r_ptr + 1'b1;
            if (w_wr_en) begin
                r_bank[r_ptr] <= w_wr_byte;
                if (w_ptr_last) begin
                    r_valid <= 1'b1;
                end
            end
            // Reads sample the pre-write contents (read-before-write).
            if (spi_bus.rd_en_i) begin
                if ({1'b0, spi_bus.rd_addr_i} < GROUPS_W) begin
                    r_rd_data <= r_bank[spi_bus.rd_addr_i[PTR_W-1:0]];
                end else begin
                    r_rd_data <= 8'h00;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_scan_snapshot.sv
module tb_key_scan_snapshot;
    localparam int NK  = 61;
    localparam int TP  = 400;
    localparam int DD  = 4;
    localparam logic [NK-1:0] ALL1 = '1;

    logic          clk_g_int_buf;
    logic          rstn_g_i;
    logic [NK-1:0] keys_i;
    logic [NK-1:0] keys_o;
    logic          key_tick_o;
    logic          keys_valid_o;

    key_scan_snapshot_if bus ();

    key_scan_snapshot #(
        .NUM_KEYS       (NK),
        .TICK_PERIOD    (TP),
        .DEBOUNCE_DEPTH (DD)
    ) dut (
        .clk_g_int_buf (clk_g_int_buf),
        .rstn_g_i      (rstn_g_i),
        .keys_i        (keys_i),
        .spi_bus       (bus),
        .keys_o        (keys_o),
        .key_tick_o    (key_tick_o),
        .keys_valid_o  (keys_valid_o)
    );

    initial clk_g_int_buf = 1'b0;
    always #5 clk_g_int_buf = ~clk_g_int_buf;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read: strobe for one cycle, check data at the following negedge.
    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        bus.rd_addr_i = a;
        bus.rd_en_i   = 1'b1;
        @(negedge clk_g_int_buf);
        bus.rd_en_i   = 1'b0;
        chk(tag, 64'(bus.rd_data_o), 64'(exp));
    endtask

    // Wait for a tick pulse, then one more cycle so its debounce update is visible.
    task automatic wait_tick();
        logic got;
        got = 1'b0;
        for (int c = 0; c < TP + 5; c++) begin
            @(negedge clk_g_int_buf);
            if (key_tick_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("tick_timeout", 64'(got), 64'd1);
        @(negedge clk_g_int_buf);
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) wait_tick();
    endtask

    initial begin
        int first_tick;
        int first_valid;

        rstn_g_i      = 1'b0;
        keys_i        = '0;
        bus.hold_i    = 1'b0;
        bus.rd_en_i   = 1'b0;
        bus.rd_addr_i = 8'h00;
        repeat (3) @(negedge clk_g_int_buf);
        chk("rst_keys_o", 64'(keys_o), 64'd0);
        chk("rst_valid", 64'(keys_valid_o), 64'd0);
        chk("rst_tick", 64'(key_tick_o), 64'd0);
        chk("rst_rd_data", 64'(bus.rd_data_o), 64'd0);

        // Release at a negedge; i counts rising edges since release.
        rstn_g_i    = 1'b1;
        first_tick  = -1;
        first_valid = -1;
        for (int i = 1; i <= TP; i++) begin
            @(negedge clk_g_int_buf);
            if (key_tick_o && first_tick < 0) first_tick = i + 1;
            if (keys_valid_o && first_valid < 0) first_valid = i;
        end
        chk("first_tick_cycle", 64'(first_tick), 64'd400);
        chk("tick_one_cycle", 64'(key_tick_o), 64'd0);
        chk("valid_after_sweep", 64'(first_valid), 64'd8);
        for (int a = 0; a < 8; a++) rd(8'(a), 8'h00, "idle_addr");
        rd(8'd200, 8'h00, "idle_addr200");

        // Key 9: qualifies on the 4th tick after it is seen.
        keys_i[9] = 1'b1;
        wait_ticks(3);
        chk("key9_after3", 64'(keys_o), 64'd0);
        wait_tick();
        chk("key9_after4", 64'(keys_o), 64'h200);
        repeat (8) @(negedge clk_g_int_buf);
        rd(8'd1, 8'h02, "key9_addr1");
        rd(8'd0, 8'h00, "key9_addr0");
        rd(8'd7, 8'h00, "key9_addr7");

        // Key 60 lives in bit 4 of group 7.
        keys_i[60] = 1'b1;
        wait_ticks(4);
        repeat (8) @(negedge clk_g_int_buf);
        rd(8'd7, 8'h10, "key60_addr7");
        keys_i = ALL1;
        wait_ticks(4);
        chk("all_keys_o", 64'(keys_o), 64'(ALL1));
        repeat (8) @(negedge clk_g_int_buf);
        rd(8'd7, 8'h1F, "all_addr7_pad");
        rd(8'd0, 8'hFF, "all_addr0");
        rd(8'd8, 8'h00, "all_addr8_oob");
        rd(8'd255, 8'h00, "all_addr255_oob");
        bus.rd_addr_i = 8'd3;
        repeat (2) @(negedge clk_g_int_buf);
        chk("rd_data_hold", 64'(bus.rd_data_o), 64'h00);

        // Glitch on key 3 lasting two tick samples must not pass.
        keys_i = '0;
        wait_ticks(4);
        chk("release_all", 64'(keys_o), 64'd0);
        keys_i[3] = 1'b1;
        wait_ticks(2);
        keys_i[3] = 1'b0;
        chk("glitch_k3_mid", 64'(keys_o[3]), 64'd0);
        for (int k = 0; k < 4; k++) begin
            wait_tick();
            chk("glitch_k3", 64'(keys_o[3]), 64'd0);
            rd(8'd0, 8'h00, "glitch_addr0");
        end

        // Hold freezes the bank while debounce continues.
        bus.hold_i = 1'b1;
        keys_i[0]  = 1'b1;
        wait_ticks(4);
        chk("hold_keys_o", 64'(keys_o), 64'd1);
        repeat (10) @(negedge clk_g_int_buf);
        rd(8'd0, 8'h00, "hold_addr0");
        bus.hold_i = 1'b0;
        repeat (8) @(negedge clk_g_int_buf);
        rd(8'd0, 8'h01, "unhold_addr0");

        // Mid-run reset with keys pressed.
        keys_i = ALL1;
        wait_ticks(4);
        repeat (8) @(negedge clk_g_int_buf);
        rd(8'd3, 8'hFF, "pre_rst_addr3");
        rstn_g_i = 1'b0;
        #1;
        chk("mrst_keys_o", 64'(keys_o), 64'd0);
        chk("mrst_valid", 64'(keys_valid_o), 64'd0);
        chk("mrst_rd_data", 64'(bus.rd_data_o), 64'd0);
        @(negedge clk_g_int_buf);
        rstn_g_i = 1'b1;
        // First edge after release writes only entry 0, so entry 3 shows the reset value.
        rd(8'd3, 8'h00, "mrst_bank3");
        wait_ticks(3);
        chk("mrst_requal3", 64'(keys_o), 64'd0);
        chk("mrst_valid_again", 64'(keys_valid_o), 64'd1);
        wait_tick();
        chk("mrst_requal4", 64'(keys_o), 64'(ALL1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
